// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage with IF/ID pipeline register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic        JumpD,
    input  logic        CLR,
    input  logic [31:0] ImemRdataF,
    output logic [31:0] ImemAddrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    logic [31:0] pc_plus4_f;
    logic [31:0] pc_branch_d;
    logic [31:0] pc_jump_d;
    logic [31:0] pc_next;

    assign pc_plus4_f  = PCF + 32'd4;
    assign ImemAddrF   = PCF;
    assign pc_branch_d = PCPlus4D + {{14{InstrD[15]}}, InstrD[15:0], 2'b00};
    assign pc_jump_d   = {PCPlus4D[31:28], InstrD[25:0], 2'b00};

    // Jump outranks a taken branch when both are flagged in the same cycle.
    always_comb begin
        pc_next = pc_plus4_f;
        if (JumpD) begin
            pc_next = pc_jump_d;
        end else if (PCSrcD) begin
            pc_next = pc_branch_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PCF <= RESET_PC;
        end else if (!StallF) begin
            PCF <= pc_next;
        end
    end

    // A stalled decode stage must keep its instruction even when a flush is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            InstrD   <= NOP_INSTR;
            PCPlus4D <= 32'h0000_0000;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (CLR) begin
                InstrD   <= NOP_INSTR;
                PCPlus4D <= 32'h0000_0000;
                ValidD   <= 1'b0;
            end else begin
                InstrD   <= ImemRdataF;
                PCPlus4D <= pc_plus4_f;
                ValidD   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        StallF;
    logic        StallD;
    logic        PCSrcD;
    logic        JumpD;
    logic        CLR;
    logic [31:0] ImemRdataF;
    logic [31:0] ImemAddrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .StallD     (StallD),
        .PCSrcD     (PCSrcD),
        .JumpD      (JumpD),
        .CLR        (CLR),
        .ImemRdataF (ImemRdataF),
        .ImemAddrF  (ImemAddrF),
        .PCF        (PCF),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default word at address a is 32'h2008_0000 + a/4, with a few redirect instructions planted.
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0010: imem = 32'h1000_FFFE;
            32'h0000_0018: imem = 32'h1000_8000;
            32'hFFFE_001C: imem = 32'h0BFF_FFFF;
            32'hFFFF_FFFC: imem = 32'h0800_0040;
            default:       imem = 32'h2008_0000 + {2'b00, a[31:2]};
        endcase
    endfunction

    assign ImemRdataF = imem(ImemAddrF);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] p4, input logic v);
        chk({tag, ".PCF"}, PCF, pc);
        chk({tag, ".ImemAddrF"}, ImemAddrF, pc);
        chk({tag, ".InstrD"}, InstrD, instr);
        chk({tag, ".PCPlus4D"}, PCPlus4D, p4);
        chk({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0; CLR = 1'b0;
        step();
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;

        step();
        chk_all("seq1", 32'h4, 32'h2008_0000, 32'h4, 1'b1);
        step();
        chk_all("seq2", 32'h8, 32'h2008_0001, 32'h8, 1'b1);

        StallF = 1'b1; StallD = 1'b1;
        step();
        chk_all("stall1", 32'h8, 32'h2008_0001, 32'h8, 1'b1);
        step();
        chk_all("stall2", 32'h8, 32'h2008_0001, 32'h8, 1'b1);
        StallF = 1'b0; StallD = 1'b0;
        step();
        chk_all("release", 32'hC, 32'h2008_0002, 32'hC, 1'b1);
        step();
        chk_all("seq3", 32'h10, 32'h2008_0003, 32'h10, 1'b1);
        step();
        chk_all("beq_in_d", 32'h14, 32'h1000_FFFE, 32'h14, 1'b1);

        PCSrcD = 1'b1; CLR = 1'b1;
        step();
        chk_all("beq_taken", 32'hC, 32'h0, 32'h0, 1'b0);
        PCSrcD = 1'b0; CLR = 1'b0;
        step();
        chk_all("beq_after", 32'h10, 32'h2008_0003, 32'h10, 1'b1);
        step();
        chk_all("beq_not_taken", 32'h14, 32'h1000_FFFE, 32'h14, 1'b1);
        step();
        chk_all("seq4", 32'h18, 32'h2008_0005, 32'h18, 1'b1);
        step();
        chk_all("longbeq_in_d", 32'h1C, 32'h1000_8000, 32'h1C, 1'b1);

        PCSrcD = 1'b1; CLR = 1'b1;
        step();
        chk_all("longbeq_taken", 32'hFFFE_001C, 32'h0, 32'h0, 1'b0);
        PCSrcD = 1'b0; CLR = 1'b0;
        step();
        chk_all("j_in_d", 32'hFFFE_0020, 32'h0BFF_FFFF, 32'hFFFE_0020, 1'b1);

        JumpD = 1'b1; PCSrcD = 1'b1; CLR = 1'b1;
        step();
        chk_all("j_over_beq", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        JumpD = 1'b0; PCSrcD = 1'b0; CLR = 1'b0;
        step();
        chk_all("wrap", 32'h0, 32'h0800_0040, 32'h0, 1'b1);

        JumpD = 1'b1; CLR = 1'b1;
        step();
        chk_all("j_taken", 32'h100, 32'h0, 32'h0, 1'b0);
        JumpD = 1'b0; CLR = 1'b0;
        step();
        chk_all("j_after", 32'h104, 32'h2008_0040, 32'h104, 1'b1);

        StallF = 1'b1; StallD = 1'b1; CLR = 1'b1;
        step();
        chk_all("stall_clr", 32'h104, 32'h2008_0040, 32'h104, 1'b1);
        CLR = 1'b0; StallD = 1'b0;
        step();
        chk_all("refetch1", 32'h104, 32'h2008_0041, 32'h108, 1'b1);
        step();
        chk_all("refetch2", 32'h104, 32'h2008_0041, 32'h108, 1'b1);

        StallD = 1'b1; PCSrcD = 1'b1; rst = 1'b1;
        step();
        chk_all("rst_in_stall", 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0;
        step();
        chk_all("post_rst", 32'h4, 32'h2008_0000, 32'h4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
